nv_nvdla_glb_cacc_intr: RTL and testbench

NV_NVDLA_GLB_CACC_INTR -- requirements
Module: nv_nvdla_glb_cacc_intr

---
 rtl/nv_nvdla_glb_cacc_intr_if.sv | 37 +++
 rtl/nv_nvdla_glb_cacc_intr.sv | 97 +++++++++
 tb/tb_nv_nvdla_glb_cacc_intr.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nv_nvdla_glb_cacc_intr_if.sv
`default_nettype none
// ============================================================================
// Module      : nv_nvdla_glb_cacc_intr_if
// Description : CACC done-interrupt bundle: done pulses, register strobes and
//               the status/mask/counter read-back outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface nv_nvdla_glb_cacc_intr_if #(
   parameter int CNT_W = 8
);
   logic [1:0]       cacc2glb_done_intr_dst_pd;
   logic             reg_mask_wr_en;
   logic [1:0]       reg_mask_wr_data;
   logic             reg_status_clr_en;
   logic [1:0]       reg_status_clr_data;
   logic [1:0]       cacc_done_status;
   logic [1:0]       cacc_done_ovf;
   logic [1:0]       cacc_done_mask;
   logic [CNT_W-1:0] cacc_done_cnt0;
   logic [CNT_W-1:0] cacc_done_cnt1;
   logic             core_intr;

   modport master (
      output cacc2glb_done_intr_dst_pd, reg_mask_wr_en, reg_mask_wr_data,
             reg_status_clr_en, reg_status_clr_data,
      input  cacc_done_status, cacc_done_ovf, cacc_done_mask,
             cacc_done_cnt0, cacc_done_cnt1, core_intr
   );

   modport slave (
      input  cacc2glb_done_intr_dst_pd, reg_mask_wr_en, reg_mask_wr_data,
             reg_status_clr_en, reg_status_clr_data,
      output cacc_done_status, cacc_done_ovf, cacc_done_mask,
             cacc_done_cnt0, cacc_done_cnt1, core_intr
   );
endinterface
`default_nettype wire

// File: rtl/nv_nvdla_glb_cacc_intr.sv
`default_nettype none
// ============================================================================
// Module      : nv_nvdla_glb_cacc_intr
// Description : Sticky per-group CACC done status with overflow, mask and a
//               registered interrupt. Optional saturating done counters are
//               built when NVDLA_GLB_CACC_INTR_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module nv_nvdla_glb_cacc_intr #(
   parameter int CNT_W = 8
) (
   input  wire logic                   nvdla_core_clk,
   input  wire logic                   nvdla_core_rstn,
   nv_nvdla_glb_cacc_intr_if.slave     intr_if
);

   logic [1:0] w_pd;
   logic [1:0] w_clr;
   logic [1:0] status_q, status_d;
   logic [1:0] ovf_q,    ovf_d;
   logic [1:0] mask_q,   mask_d;
   logic       intr_q,   intr_d;

   assign w_pd  = intr_if.cacc2glb_done_intr_dst_pd;
   assign w_clr = {2{intr_if.reg_status_clr_en}} & intr_if.reg_status_clr_data;

   // A done pulse beats a same-cycle clear: status stays set, overflow drops.
   always_comb begin
      status_d = w_pd | (status_q & ~w_clr);
      ovf_d    = ovf_q;
      for (int g = 0; g < 2; g++) begin
         if (w_clr[g]) begin
            ovf_d[g] = 1'b0;
         end else if (w_pd[g] && status_q[g]) begin
            ovf_d[g] = 1'b1;
         end
      end
      mask_d = intr_if.reg_mask_wr_en ? intr_if.reg_mask_wr_data : mask_q;
      intr_d = |(status_q & ~mask_q);
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         status_q <= 2'b00;
         ovf_q    <= 2'b00;
         mask_q   <= 2'b00;
         intr_q   <= 1'b0;
      end else begin
         status_q <= status_d;
         ovf_q    <= ovf_d;
         mask_q   <= mask_d;
         intr_q   <= intr_d;
      end
   end

   assign intr_if.cacc_done_status = status_q;
   assign intr_if.cacc_done_ovf    = ovf_q;
   assign intr_if.cacc_done_mask   = mask_q;
   assign intr_if.core_intr        = intr_q;

`ifdef NVDLA_GLB_CACC_INTR_CNT_EN
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];

   // Counter clears with status; a pulse in the clearing cycle counts as one.
   always_comb begin
      for (int g = 0; g < 2; g++) begin
         cnt_d[g] = cnt_q[g];
         if (w_clr[g]) begin
            cnt_d[g] = w_pd[g] ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
         end else if (w_pd[g] && (cnt_q[g] != C_CNT_MAX)) begin
            cnt_d[g] = cnt_q[g] + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cnt_q[0] <= {CNT_W{1'b0}};
         cnt_q[1] <= {CNT_W{1'b0}};
      end else begin
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
      end
   end

   assign intr_if.cacc_done_cnt0 = cnt_q[0];
   assign intr_if.cacc_done_cnt1 = cnt_q[1];
`else
   assign intr_if.cacc_done_cnt0 = {CNT_W{1'b0}};
   assign intr_if.cacc_done_cnt1 = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_glb_cacc_intr.sv
`default_nettype none
// ============================================================================
// Module      : tb_nv_nvdla_glb_cacc_intr
// Description : Directed self-checking bench for nv_nvdla_glb_cacc_intr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_nvdla_glb_cacc_intr;

   localparam int CNT_W = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   nv_nvdla_glb_cacc_intr_if #(.CNT_W(CNT_W)) bus ();

   nv_nvdla_glb_cacc_intr #(.CNT_W(CNT_W)) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .intr_if         (bus)
   );

   always #5 clk = ~clk;

`ifdef NVDLA_GLB_CACC_INTR_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   function automatic logic [CNT_W-1:0] exp_cnt(input int v);
      return CNT_ON ? CNT_W'(v) : {CNT_W{1'b0}};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cacc2glb_done_intr_dst_pd = 2'b00;
      bus.reg_mask_wr_en            = 1'b0;
      bus.reg_mask_wr_data          = 2'b00;
      bus.reg_status_clr_en         = 1'b0;
      bus.reg_status_clr_data       = 2'b00;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 rstn = 1'b0;
      repeat (3) cyc();
      n_checks++;
      if ({bus.cacc_done_status, bus.cacc_done_ovf, bus.cacc_done_mask, bus.core_intr} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_state: got st=%b ovf=%b mask=%b intr=%b, want all 0",
                  bus.cacc_done_status, bus.cacc_done_ovf, bus.cacc_done_mask, bus.core_intr);
      end
      n_checks++;
      if ({bus.cacc_done_cnt0, bus.cacc_done_cnt1} !== '0) begin
         n_fail++;
         $display("FAIL reset_cnt: got cnt0=%0d cnt1=%0d, want 0 0", bus.cacc_done_cnt0, bus.cacc_done_cnt1);
      end
      rstn = 1'b1;
      cyc();
   endtask

   task automatic test_set();
      bus.cacc2glb_done_intr_dst_pd = 2'b01;
      cyc();
      bus.cacc2glb_done_intr_dst_pd = 2'b00;
      n_checks++;
      if (bus.cacc_done_status !== 2'b01 || bus.core_intr !== 1'b0 || bus.cacc_done_ovf !== 2'b00) begin
         n_fail++;
         $display("FAIL set_lat1: got st=%b intr=%b ovf=%b, want 01 0 00",
                  bus.cacc_done_status, bus.core_intr, bus.cacc_done_ovf);
      end
      cyc();
      n_checks++;
      if (bus.core_intr !== 1'b1) begin
         n_fail++;
         $display("FAIL set_intr_lat2: got intr=%b, want 1", bus.core_intr);
      end
   endtask

   task automatic test_ovf_clear();
      bus.cacc2glb_done_intr_dst_pd = 2'b01;
      cyc();
      bus.cacc2glb_done_intr_dst_pd = 2'b00;
      n_checks++;
      if (bus.cacc_done_ovf !== 2'b01 || bus.cacc_done_status !== 2'b01) begin
         n_fail++;
         $display("FAIL ovf_set: got ovf=%b st=%b, want 01 01", bus.cacc_done_ovf, bus.cacc_done_status);
      end
      n_checks++;
      if (bus.cacc_done_cnt0 !== exp_cnt(2)) begin
         n_fail++;
         $display("FAIL cnt0_two: got %0d, want %0d", bus.cacc_done_cnt0, exp_cnt(2));
      end
      bus.reg_status_clr_en   = 1'b1;
      bus.reg_status_clr_data = 2'b01;
      cyc();
      idle_inputs();
      n_checks++;
      if (bus.cacc_done_status !== 2'b00 || bus.cacc_done_ovf !== 2'b00 || bus.core_intr !== 1'b1) begin
         n_fail++;
         $display("FAIL w1c: got st=%b ovf=%b intr=%b, want 00 00 1",
                  bus.cacc_done_status, bus.cacc_done_ovf, bus.core_intr);
      end
      cyc();
      n_checks++;
      if (bus.core_intr !== 1'b0) begin
         n_fail++;
         $display("FAIL w1c_intr: got intr=%b, want 0", bus.core_intr);
      end
   endtask

   task automatic test_collision();
      bus.cacc2glb_done_intr_dst_pd = 2'b10;
      bus.reg_status_clr_en         = 1'b1;
      bus.reg_status_clr_data       = 2'b10;
      cyc();
      idle_inputs();
      n_checks++;
      if (bus.cacc_done_status !== 2'b10 || bus.cacc_done_ovf !== 2'b00) begin
         n_fail++;
         $display("FAIL set_wins: got st=%b ovf=%b, want 10 00", bus.cacc_done_status, bus.cacc_done_ovf);
      end
      n_checks++;
      if (bus.cacc_done_cnt1 !== exp_cnt(1)) begin
         n_fail++;
         $display("FAIL cnt1_collision: got %0d, want %0d", bus.cacc_done_cnt1, exp_cnt(1));
      end
      bus.reg_status_clr_en   = 1'b0;
      bus.reg_status_clr_data = 2'b11;
      cyc();
      idle_inputs();
      n_checks++;
      if (bus.cacc_done_status !== 2'b10 || bus.cacc_done_cnt1 !== exp_cnt(1)) begin
         n_fail++;
         $display("FAIL clr_en_low: got st=%b cnt1=%0d, want 10 %0d",
                  bus.cacc_done_status, bus.cacc_done_cnt1, exp_cnt(1));
      end
      bus.reg_status_clr_en   = 1'b1;
      bus.reg_status_clr_data = 2'b11;
      cyc();
      idle_inputs();
      cyc();
   endtask

   task automatic test_counter();
      for (int i = 0; i < 300; i++) begin
         bus.cacc2glb_done_intr_dst_pd = 2'b01;
         cyc();
         if (i == 9) begin
            n_checks++;
            if (bus.cacc_done_cnt0 !== exp_cnt(10)) begin
               n_fail++;
               $display("FAIL cnt0_ten: got %0d, want %0d", bus.cacc_done_cnt0, exp_cnt(10));
            end
         end
      end
      idle_inputs();
      n_checks++;
      if (bus.cacc_done_cnt0 !== exp_cnt(255) || bus.cacc_done_cnt1 !== exp_cnt(0)) begin
         n_fail++;
         $display("FAIL cnt_sat: got cnt0=%0d cnt1=%0d, want %0d 0",
                  bus.cacc_done_cnt0, bus.cacc_done_cnt1, exp_cnt(255));
      end
      n_checks++;
      if (bus.cacc_done_status !== 2'b01 || bus.cacc_done_ovf !== 2'b01) begin
         n_fail++;
         $display("FAIL cnt_status: got st=%b ovf=%b, want 01 01", bus.cacc_done_status, bus.cacc_done_ovf);
      end
      bus.reg_status_clr_en   = 1'b1;
      bus.reg_status_clr_data = 2'b01;
      cyc();
      idle_inputs();
      n_checks++;
      if (bus.cacc_done_cnt0 !== exp_cnt(0) || bus.cacc_done_status !== 2'b00) begin
         n_fail++;
         $display("FAIL cnt_clear: got cnt0=%0d st=%b, want 0 00", bus.cacc_done_cnt0, bus.cacc_done_status);
      end
      cyc();
   endtask

   task automatic test_mask();
      bus.reg_mask_wr_en   = 1'b1;
      bus.reg_mask_wr_data = 2'b11;
      cyc();
      idle_inputs();
      n_checks++;
      if (bus.cacc_done_mask !== 2'b11) begin
         n_fail++;
         $display("FAIL mask_load: got %b, want 11", bus.cacc_done_mask);
      end
      bus.cacc2glb_done_intr_dst_pd = 2'b11;
      cyc();
      idle_inputs();
      n_checks++;
      if (bus.cacc_done_status !== 2'b11) begin
         n_fail++;
         $display("FAIL both_set: got st=%b, want 11", bus.cacc_done_status);
      end
      repeat (2) cyc();
      n_checks++;
      if (bus.core_intr !== 1'b0) begin
         n_fail++;
         $display("FAIL masked_intr: got intr=%b, want 0", bus.core_intr);
      end
      bus.reg_mask_wr_en   = 1'b1;
      bus.reg_mask_wr_data = 2'b01;
      cyc();
      idle_inputs();
      n_checks++;
      if (bus.cacc_done_mask !== 2'b01 || bus.core_intr !== 1'b0 ||
          bus.cacc_done_status !== 2'b11 || bus.cacc_done_ovf !== 2'b00) begin
         n_fail++;
         $display("FAIL unmask_lat1: got mask=%b intr=%b st=%b ovf=%b, want 01 0 11 00",
                  bus.cacc_done_mask, bus.core_intr, bus.cacc_done_status, bus.cacc_done_ovf);
      end
      cyc();
      n_checks++;
      if (bus.core_intr !== 1'b1) begin
         n_fail++;
         $display("FAIL unmask_lat2: got intr=%b, want 1", bus.core_intr);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if ({bus.cacc_done_status, bus.cacc_done_ovf, bus.cacc_done_mask, bus.core_intr} !== 7'b0 ||
          {bus.cacc_done_cnt0, bus.cacc_done_cnt1} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got st=%b ovf=%b mask=%b intr=%b cnt0=%0d, want all 0",
                  bus.cacc_done_status, bus.cacc_done_ovf, bus.cacc_done_mask, bus.core_intr,
                  bus.cacc_done_cnt0);
      end
      bus.cacc2glb_done_intr_dst_pd = 2'b11;
      repeat (2) cyc();
      n_checks++;
      if (bus.cacc_done_status !== 2'b00 || bus.cacc_done_cnt0 !== '0) begin
         n_fail++;
         $display("FAIL pulse_in_reset: got st=%b cnt0=%0d, want 00 0", bus.cacc_done_status, bus.cacc_done_cnt0);
      end
      @(negedge clk);
      #2;
      rstn = 1'b1;
      bus.cacc2glb_done_intr_dst_pd = 2'b01;
      cyc();
      idle_inputs();
      n_checks++;
      if (bus.cacc_done_status !== 2'b01 || bus.cacc_done_cnt0 !== exp_cnt(1)) begin
         n_fail++;
         $display("FAIL first_edge: got st=%b cnt0=%0d, want 01 %0d",
                  bus.cacc_done_status, bus.cacc_done_cnt0, exp_cnt(1));
      end
   endtask

   initial begin
      test_reset();
      test_set();
      test_ovf_clear();
      test_collision();
      test_counter();
      test_mask();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
